// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        TRAP = 2'd3
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_SEQ  = 3'd1,
        SEL_BR   = 3'd2,
        SEL_JMP  = 3'd3,
        SEL_TRAP = 3'd4
    } pc_sel_e;

    // Low PC bits that must be zero for a fetchable address.
    localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority encoder and mux: halt > trap > stall > jump > branch > sequential.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter bit              TRAP_EN  = 1'b0,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100)
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_inc,
    input  logic            halt,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jmp,
    input  logic [XLEN-1:0] jmp_target,
    output pc_sel_e         sel_c,
    output logic [XLEN-1:0] next_pc_c
);

    logic [XLEN-1:0] br_aligned;
    logic [XLEN-1:0] jmp_aligned;
    logic            misaligned;

    // Masking both low bits also clears jump bit0.
    assign br_aligned  = {br_target[XLEN-1:2], br_target[1:0] & ~PC_ALIGN_MASK};
    assign jmp_aligned = {jmp_target[XLEN-1:2], jmp_target[1:0] & ~PC_ALIGN_MASK};

    // Only the redirect that would actually win can fault.
    assign misaligned = TRAP_EN && (jmp ? jmp_target[1] : (br_taken && br_target[1]));

    always_comb begin
        sel_c     = SEL_SEQ;
        next_pc_c = pc_inc;
        if (halt) begin
            sel_c     = SEL_HOLD;
            next_pc_c = pc;
        end else if (misaligned) begin
            sel_c     = SEL_TRAP;
            next_pc_c = TRAP_VEC;
        end else if (stall) begin
            sel_c     = SEL_HOLD;
            next_pc_c = pc;
        end else if (jmp) begin
            sel_c     = SEL_JMP;
            next_pc_c = jmp_aligned;
        end else if (br_taken) begin
            sel_c     = SEL_BR;
            next_pc_c = br_aligned;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter unit: control FSM and PC register for the single-cycle core.
// Optional misaligned-target trapping is enabled by defining PC_TRAP_EN.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0000),
    parameter int unsigned     INC       = 4,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            jmp_i,
    input  logic [XLEN-1:0] jmp_target_i,
    input  logic            halt_i,
    input  logic            resume_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_inc_o,
    output logic            valid_o
`ifdef PC_TRAP_EN
    ,
    output logic [XLEN-1:0] epc_o,
    output logic            trap_o
`endif
);

`ifdef PC_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    pc_state_e       state_q;
    pc_state_e       state_d;
    pc_sel_e         sel;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] sel_pc;
    logic            valid_q;
    logic            valid_d;

    // Wraps modulo 2^XLEN by construction.
    assign pc_inc = pc_q + XLEN'(INC);

    pc_next_sel #(
        .XLEN     (XLEN),
        .TRAP_EN  (TRAP_EN),
        .TRAP_VEC (TRAP_VEC)
    ) u_next_sel (
        .pc         (pc_q),
        .pc_inc     (pc_inc),
        .halt       (halt_i),
        .stall      (stall_i),
        .br_taken   (br_taken_i),
        .br_target  (br_target_i),
        .jmp        (jmp_i),
        .jmp_target (jmp_target_i),
        .sel_c      (sel),
        .next_pc_c  (sel_pc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (halt_i) begin
                    state_d = HALT;
                end else if (sel == SEL_TRAP) begin
                    state_d = TRAP;
                end
            end
            HALT: begin
                if (resume_i && !halt_i) begin
                    state_d = RUN;
                end
            end
            TRAP:    state_d = halt_i ? HALT : RUN;
            default: state_d = BOOT;
        endcase
    end

    // The trap cycle fetches TRAP_VEC, so the handler continues sequentially afterwards.
    always_comb begin
        pc_d    = pc_q;
        valid_d = (state_d == RUN) || (state_d == TRAP);
        case (state_q)
            RUN: pc_d = sel_pc;
            TRAP: begin
                if (!halt_i && !stall_i) begin
                    pc_d = pc_inc;
                end
            end
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o     = pc_q;
    assign pc_inc_o = pc_inc;
    assign valid_o  = valid_q;

`ifdef PC_TRAP_EN
    logic [XLEN-1:0] epc_q;
    logic            trap_q;

    // Capture the raw (unaligned) target that caused the trap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            epc_q  <= '0;
            trap_q <= 1'b0;
        end else begin
            trap_q <= (state_d == TRAP);
            if (state_q == RUN && state_d == TRAP) begin
                epc_q <= jmp_i ? jmp_target_i : br_target_i;
            end
        end
    end

    assign epc_o  = epc_q;
    assign trap_o = trap_q;
`endif

endmodule
